fetch_operand_sequencer: RTL

//  Multi-cycle control FSM that issues, in order, the strobes the datapath needs to:
//   1. read the PC from the register file;
//   2. fetch the instruction from instruction memory;
//   3. read the source registers;
//   4. enable the shifter and write back the next PC.

---
 rtl/fetch_operand_sequencer_pkg.sv | 17 +
 rtl/fetch_operand_sequencer.sv | 112 +++++++++++
 2 files changed

// File: rtl/fetch_operand_sequencer_pkg.sv
// Shared definitions for the fetch/operand sequencer: FSM states and the
// instruction fields that select a register-specified shift.
package fetch_operand_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH_PC,
        ST_FETCH_INST,
        ST_READ_REGS,
        ST_SHIFT,
        ST_ISSUE
    } fos_state_t;

    localparam int unsigned IMM_BIT    = 25;
    localparam int unsigned RSHIFT_BIT = 4;

endpackage

// File: rtl/fetch_operand_sequencer.sv
// Multi-cycle strobe sequencer: PC read, instruction fetch, register read,
// shift + PC writeback, then an op_valid/op_ready handshake to execute.
module fetch_operand_sequencer
    import fetch_operand_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned PC_STEP = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic [ADDR_W-1:0] pc_data,
    input  logic [DATA_W-1:0] inst,
    input  logic              op_ready,
    output logic              rd_pc,
    output logic              rd_inst,
    output logic              rd_1,
    output logic              rd_2,
    output logic              rd_3,
    output logic              shft_en,
    output logic              wr_pc,
    output logic [ADDR_W-1:0] pc_next,
    output logic [DATA_W-1:0] inst_q,
    output logic              op_valid,
    output logic [CNT_W-1:0]  issue_count
);

    fos_state_t        state, state_nxt;
    logic [ADDR_W-1:0] pc_q;
    logic              load_pc, load_inst, accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            pc_q        <= '0;
            inst_q      <= '0;
            issue_count <= '0;
        end else begin
            state <= state_nxt;
            if (load_pc)   pc_q        <= pc_data;
            if (load_inst) inst_q      <= inst;
            if (accept)    issue_count <= issue_count + CNT_W'(1);
        end
    end

    // Outputs are gated by rst so they clear immediately, not at the next edge.
    always_comb begin
        state_nxt = state;
        load_pc   = 1'b0;
        load_inst = 1'b0;
        accept    = 1'b0;
        rd_pc     = 1'b0;
        rd_inst   = 1'b0;
        rd_1      = 1'b0;
        rd_2      = 1'b0;
        rd_3      = 1'b0;
        shft_en   = 1'b0;
        wr_pc     = 1'b0;
        pc_next   = '0;
        op_valid  = 1'b0;
        if (!rst) begin
            if (redirect_valid) begin
                wr_pc   = 1'b1;
                pc_next = redirect_pc;
                if (state != ST_IDLE)               state_nxt = ST_FETCH_PC;
                if (state == ST_ISSUE && op_ready)  accept    = 1'b1;
            end else if (stall) begin
                op_valid = (state == ST_ISSUE);
            end else begin
                unique case (state)
                    ST_IDLE: if (start) state_nxt = ST_FETCH_PC;
                    ST_FETCH_PC: begin
                        rd_pc     = 1'b1;
                        load_pc   = 1'b1;
                        state_nxt = ST_FETCH_INST;
                    end
                    ST_FETCH_INST: begin
                        rd_inst   = 1'b1;
                        load_inst = 1'b1;
                        state_nxt = ST_READ_REGS;
                    end
                    ST_READ_REGS: begin
                        rd_1      = 1'b1;
                        rd_2      = 1'b1;
                        rd_3      = !inst_q[IMM_BIT] && inst_q[RSHIFT_BIT];
                        state_nxt = ST_SHIFT;
                    end
                    ST_SHIFT: begin
                        shft_en   = 1'b1;
                        wr_pc     = 1'b1;
                        pc_next   = pc_q + ADDR_W'(PC_STEP);
                        state_nxt = ST_ISSUE;
                    end
                    ST_ISSUE: begin
                        op_valid = 1'b1;
                        if (op_ready) begin
                            accept    = 1'b1;
                            state_nxt = start ? ST_FETCH_PC : ST_IDLE;
                        end
                    end
                    default: state_nxt = ST_IDLE;
                endcase
            end
        end
    end

endmodule
